// File: rtl/shift_r_iter.sv
// Iterative right shifter (SRL/SRA, optional rotate) moving up to STEP bits per clock.
// Define SHIFT_R_ROTATE_EN to enable rotate-right on i_rot; otherwise i_rot is ignored.
module shift_r_iter #(
    parameter int STEP = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_rs,
    input  logic [4:0]  i_amount,
    input  logic        i_arith,
    input  logic        i_rot,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result
);

    localparam int SW = $clog2(STEP) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_q;
    logic [31:0] work_q;
    logic [4:0]  rem_q;
    logic        arith_q;
    logic        sign_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] result_q;
`ifdef SHIFT_R_ROTATE_EN
    logic        rot_q;
`endif

    logic [SW-1:0] s_d;
    logic [4:0]    rem_d;
    logic [31:0]   fill_d;
    logic [63:0]   wide_d;
    logic [31:0]   work_d;

    // Per-cycle step: shift {fill, work} so the vacated high bits take the fill pattern.
    always_comb begin
        s_d    = (rem_q < 5'(STEP)) ? rem_q[SW-1:0] : SW'(STEP);
        rem_d  = rem_q - 5'(s_d);
`ifdef SHIFT_R_ROTATE_EN
        fill_d = rot_q ? work_q : {32{arith_q & sign_q}};
`else
        fill_d = {32{arith_q & sign_q}};
`endif
        wide_d = {fill_d, work_q} >> s_d;
        work_d = wide_d[31:0];
    end

`ifndef SHIFT_R_ROTATE_EN
    logic unused_rot;
    assign unused_rot = i_rot;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            rem_q    <= '0;
            arith_q  <= 1'b0;
            sign_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef SHIFT_R_ROTATE_EN
            rot_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        work_q  <= i_rs;
                        sign_q  <= i_rs[31];
                        arith_q <= i_arith;
`ifdef SHIFT_R_ROTATE_EN
                        rot_q   <= i_rot;
`endif
                        busy_q  <= 1'b1;
                        if (i_amount == 5'd0) begin
                            result_q <= i_rs;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            rem_q   <= i_amount;
                            state_q <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    rem_q  <= rem_d;
                    if (rem_d == 5'd0) begin
                        result_q <= work_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_shift_r_iter.sv
// Self-checking bench for shift_r_iter: directed cases, randomized ops against a reference model.
// Honors SHIFT_R_ROTATE_EN for rotate expectations.
module tb_shift_r_iter;

    localparam int STEP = 4;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [31:0] i_rs;
    logic [4:0]  i_amount;
    logic        i_arith;
    logic        i_rot;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_result;

    int passed = 0;
    int total  = 0;

    shift_r_iter #(.STEP(STEP)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (i_start),
        .i_rs     (i_rs),
        .i_amount (i_amount),
        .i_arith  (i_arith),
        .i_rot    (i_rot),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] rs, input logic [4:0] amt,
                                              input logic ar, input logic rt);
        int n;
        n = int'(amt);
`ifdef SHIFT_R_ROTATE_EN
        if (rt) begin
            if (n == 0) return rs;
            return (rs >> n) | (rs << (32 - n));
        end
`else
        if (rt) begin end
`endif
        if (ar) return 32'($signed(rs) >>> n);
        return rs >> n;
    endfunction

    function automatic int ref_lat(input logic [4:0] amt);
        return (int'(amt) + STEP - 1) / STEP;
    endfunction

    // Issue one op, scramble inputs after acceptance, wait for o_done, then return to IDLE.
    task automatic run_op(input logic [31:0] rs, input logic [4:0] amt, input logic ar,
                          input logic rt, output int lat, output int busy_n, output bit to);
        @(negedge clk);
        i_rs = rs; i_amount = amt; i_arith = ar; i_rot = rt; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0; i_rs = $urandom; i_amount = 5'($urandom); i_arith = 1'($urandom);
        i_rot = 1'($urandom);
        lat = 0; busy_n = 0; to = 1'b0;
        while (!o_done) begin
            if (o_busy) busy_n++;
            @(posedge clk); #1;
            lat++;
            if (lat > 100) begin to = 1'b1; break; end
        end
        if (o_busy) busy_n++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; i_start = 1'b0; i_rs = '0; i_amount = '0; i_arith = 1'b0; i_rot = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({o_busy, o_done, o_result} !== 34'd0) $display("FAIL reset_outputs got busy=%b done=%b result=%h want 0 0 0", o_busy, o_done, o_result);
        else passed++;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({o_busy, o_done} !== 2'b00) $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", o_busy, o_done);
        else passed++;
    endtask

    task automatic test_directed();
        int lat, bn; bit to;
        run_op(32'h8000_0000, 5'd4, 1'b0, 1'b0, lat, bn, to);
        total++;
        if (to || o_result !== 32'h0800_0000 || lat != 1) $display("FAIL srl4 got %h lat=%0d want 08000000 lat=1", o_result, lat);
        else passed++;
        run_op(32'h8000_0000, 5'd31, 1'b1, 1'b0, lat, bn, to);
        total++;
        if (to || o_result !== 32'hFFFF_FFFF || lat != 8) $display("FAIL sra31 got %h lat=%0d want ffffffff lat=8", o_result, lat);
        else passed++;
        total++;
        if (bn != 9) $display("FAIL sra31_busy got %0d busy cycles want 9", bn);
        else passed++;
        run_op(32'h1234_5678, 5'd0, 1'b0, 1'b0, lat, bn, to);
        total++;
        if (to || o_result !== 32'h1234_5678 || lat != 0) $display("FAIL zero_amt got %h lat=%0d want 12345678 lat=0", o_result, lat);
        else passed++;
    endtask

    task automatic test_busy_ignore();
        int dones;
        @(negedge clk);
        i_rs = 32'hF000_0000; i_amount = 5'd8; i_arith = 1'b0; i_rot = 1'b0; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        i_rs = 32'hFFFF_FFFF; i_amount = 5'd1; i_arith = 1'b1; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            if (o_done) dones++;
            @(posedge clk); #1;
        end
        total++;
        if (dones != 1 || o_result !== 32'h00F0_0000) $display("FAIL busy_ignore got %0d dones result=%h want 1 00f00000", dones, o_result);
        else passed++;
        total++;
        if (o_busy !== 1'b0) $display("FAIL busy_ignore_idle got busy=%b want 0", o_busy);
        else passed++;
    endtask

    task automatic test_reset_midop();
        int lat, bn; bit to;
        @(negedge clk);
        i_rs = 32'hFFFF_0000; i_amount = 5'd20; i_arith = 1'b1; i_rot = 1'b0; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({o_busy, o_done, o_result} !== 34'd0) $display("FAIL reset_midop got busy=%b done=%b result=%h want 0 0 0", o_busy, o_done, o_result);
        else passed++;
        @(negedge clk); rst = 1'b0;
        run_op(32'h0000_0010, 5'd4, 1'b0, 1'b0, lat, bn, to);
        total++;
        if (to || o_result !== 32'h0000_0001) $display("FAIL post_reset_srl got %h want 00000001", o_result);
        else passed++;
    endtask

    task automatic test_rotate();
        int lat, bn; bit to;
        logic [31:0] exp;
`ifdef SHIFT_R_ROTATE_EN
        exp = 32'h8000_0000;
`else
        exp = 32'h0000_0000;
`endif
        run_op(32'h0000_0001, 5'd1, 1'b0, 1'b1, lat, bn, to);
        total++;
        if (to || o_result !== exp) $display("FAIL rotate1 got %h want %h", o_result, exp);
        else passed++;
    endtask

    task automatic test_random();
        int lat, bn; bit to;
        logic [31:0] rs, exp;
        logic [4:0] amt;
        logic ar, rt;
        for (int n = 0; n < 30; n++) begin
            rs = $urandom; amt = 5'($urandom); ar = 1'($urandom); rt = 1'($urandom);
            if (n < 4) amt = (n == 0) ? 5'd0 : (n == 1) ? 5'd31 : (n == 2) ? 5'd16 : 5'd5;
            exp = ref_shift(rs, amt, ar, rt);
            run_op(rs, amt, ar, rt, lat, bn, to);
            total++;
            if (to || o_result !== exp) $display("FAIL rand_result[%0d] rs=%h amt=%0d ar=%b rot=%b got %h want %h", n, rs, amt, ar, rt, o_result, exp);
            else passed++;
            total++;
            if (lat != ref_lat(amt)) $display("FAIL rand_latency[%0d] amt=%0d got %0d want %0d", n, amt, lat, ref_lat(amt));
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        int first, second, edge_n;
        logic [31:0] prev;
        prev = o_result;
        @(negedge clk);
        i_rs = 32'h0000_0F00; i_amount = 5'd4; i_arith = 1'b0; i_rot = 1'b0; i_start = 1'b1;
        first = -1; second = -1; edge_n = 0;
        @(posedge clk); #1;
        total++;
        if (o_result !== prev) $display("FAIL result_hold got %h want %h", o_result, prev);
        else passed++;
        for (int k = 0; k < 20 && second < 0; k++) begin
            if (o_done) begin
                if (first < 0) first = edge_n; else second = edge_n;
            end
            @(posedge clk); #1;
            edge_n++;
        end
        i_start = 1'b0;
        total++;
        if (first < 0 || second - first != ref_lat(5'd4) + 2) $display("FAIL b2b_spacing got first=%0d second=%0d want spacing %0d", first, second, ref_lat(5'd4) + 2);
        else passed++;
        total++;
        if (o_result !== 32'h0000_00F0) $display("FAIL b2b_result got %h want 000000f0", o_result);
        else passed++;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_midop();
        test_rotate();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
